stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Stopwatch sequencing controller. It consumes the single-cycle tick pulses from the clock divider (1 Hz, 2 Hz, 4 Hz) and debounced user controls. It maintains a MM:SS count in BCD, and manages run, pause and adjust modes. It drives the four BCD digits and per-field blanking to the seven-segment display multiplexer, which runs off the 400 Hz tick.

## Interface
Parameters: none; field limits are fixed at 00–59 for minutes and seconds.

Clock is `clk`. Reset is `rst`, synchronous and active-high. Both are decided.

- `clk` in 1: 100 MHz system clock
- `rst` in 1: synchronous active-high reset
- `one_hz_tick` in 1: 1-cycle pulse, run-mode count enable
- `two_hz_tick` in 1: 1-cycle pulse, adjust-mode increment enable
- `four_hz_tick` in 1: 1-cycle pulse, blink phase toggle
- `pause_pulse` in 1: 1-cycle pulse from debounced pause button; toggles pause
- `adj` in 1: debounced level; 1 = adjust mode
- `sel` in 1: debounced level; 0 = adjust minutes, 1 = adjust seconds
- `min_tens` out 4: BCD 0–5
- `min_ones` out 4: BCD 0–9
- `sec_tens` out 4: BCD 0–5
- `sec_ones` out 4: BCD 0–9
- `running` out 1: 1 when state is RUN
- `blank_min` out 1: 1 = display must blank both minute digits
- `blank_sec` out 1: 1 = display must blank both second digits

## Operation
- **Registers**
  - `state`: RUN, PAUSED or ADJ.
  - `paused` flag.
  - `blink_phase`.
  - Four BCD digit registers. The digit outputs are these registers directly.
- **Reset** (`rst`=1 wins over every other input)
  - Digits 0:0:0:0; `state`=RUN; `paused`=0; `blink_phase`=0.
  - `running`=1; `blank_min`=0; `blank_sec`=0.
- **State transitions** (next-state evaluated every cycle)
  - `adj`=1 → ADJ.
  - `adj`=0 → PAUSED if `paused` (next value), else RUN.
- **Pause**
  - `pause_pulse` in RUN or PAUSED toggles `paused`.
  - `pause_pulse` in ADJ is ignored; `paused` is retained across ADJ.
- **RUN**: on `one_hz_tick`, increment seconds.
  - `sec_ones` 9→0 carries into `sec_tens`.
  - Seconds 59→00 carries +1 into minutes.
  - Minutes 59→00 wrap, so 59:59 → 00:00.
  - `two_hz_tick` is ignored.
- **PAUSED**: all ticks ignored; digits hold.
- **ADJ**: on `two_hz_tick`, increment only the selected field, mod 60.
  - `sel`=0 increments minutes; seconds are untouched.
  - `sel`=1 increments seconds; there is no carry into minutes (59→00 only).
  - `one_hz_tick` is ignored.
  - `sel` is sampled on the same edge as the tick. A `sel` change mid-ADJ takes effect immediately and does not reset `blink_phase`.
- **Blink**
  - In ADJ, `blink_phase` toggles on each `four_hz_tick`, giving a 2 Hz blink.
  - In any other state, `blink_phase` is forced to 0.
  - `blank_min` = (`state`==ADJ) & ~`sel` & `blink_phase`.
  - `blank_sec` = (`state`==ADJ) & `sel` & `blink_phase`.
- **Tick handling**: ticks are level-sampled, not edge-detected. Each cycle a tick is high counts once; the clock divider guarantees 1-cycle pulses.
- **Digit range**: digit registers never hold values outside their BCD ranges. Increment logic is BCD per digit, not binary with conversion.

## Timing
- **Count latency**: a tick sampled high at edge N updates the digits at edge N; the new value is visible after edge N.
- **Mode decisions** use the registered `state` at the sampling edge.
  - The `adj` rise is effective one cycle later. A `two_hz_tick` in the same cycle as the `adj` rise is ignored; a `one_hz_tick` in that cycle still counts, since the state is still RUN.
  - The `adj` fall is effective one cycle later. A `two_hz_tick` in that cycle still adjusts.
- **`pause_pulse` and `one_hz_tick` in the same RUN cycle**: the tick counts, and `state` becomes PAUSED next cycle.
- **`running`** changes one cycle after the causing input.
- **`blank_min` / `blank_sec`** are combinational from registered `state`, registered `blink_phase` and the `sel` input. They update one cycle after a `four_hz_tick` or `adj` change, and in the same cycle as a `sel` change.
- **Reset mid-operation** (including with ticks asserted): all registers take reset values at that edge. No tick in the reset cycle has any effect.

## Test plan
1. Reset, then 3 idle cycles → digits 00:00, `running`=1, `blank_min`=`blank_sec`=0.
2. RUN, 59 `one_hz_tick` pulses → 00:59; one more → 01:00. Preload 59:59 via ADJ, return to RUN, one tick → 00:00.
3. `pause_pulse` at 00:05, then 10 `one_hz_tick` → holds 00:05, `running`=0. Second `pause_pulse` plus one tick → 00:06, `running`=1. `pause_pulse` in the same cycle as a tick at 00:06 → 00:07, then paused.
4. ADJ `sel`=1 at 00:58, two `two_hz_tick` → 00:00 with minutes unchanged. Interleaved `one_hz_tick` → no change. `sel`=0, three `two_hz_tick` from 58:00 → 01:00.
5. ADJ `sel`=0, four `four_hz_tick` → `blank_min` sequence 1,0,1,0 and `blank_sec`=0 throughout. Drop `adj` with `blink_phase`=1 → both blanks 0 within 1 cycle.
6. Pause, enter ADJ, `pause_pulse` (ignored), exit ADJ → PAUSED, `running`=0. Then `rst` asserted together with `two_hz_tick`, `one_hz_tick` and `four_hz_tick` → 00:00, RUN, `paused`=0, blanks 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// ---------------------------------------------------------------------------
// Stopwatch sequencing controller. Keeps an MM:SS count as four BCD digits
// and manages run, pause and adjust modes from divider ticks and debounced
// user controls. The digits and per-field blanking feed the seven-segment
// display multiplexer.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   one_hz_tick   in   1-cycle pulse; counts seconds in RUN
//   two_hz_tick   in   1-cycle pulse; increments the selected field in ADJ
//   four_hz_tick  in   1-cycle pulse; toggles the blink phase in ADJ
//   pause_pulse   in   1-cycle pulse; toggles pause (ignored in ADJ)
//   adj           in   level; 1 = adjust mode
//   sel           in   level; 0 = adjust minutes, 1 = adjust seconds
//   min_tens/min_ones/sec_tens/sec_ones  out  BCD digits (registers)
//   running       out  1 while state is RUN
//   blank_min     out  blank both minute digits
//   blank_sec     out  blank both second digits
//   state_dbg     out  current state (0 RUN, 1 PAUSED, 2 ADJ)
//
// Handshake note: there is no valid/ready traffic here. Every tick input is
// level-sampled, so each cycle it is high counts exactly once; the divider
// guarantees single-cycle pulses.
// ---------------------------------------------------------------------------
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_hz_tick,
  input  logic       two_hz_tick,
  input  logic       four_hz_tick,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJ    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       paused_q, paused_d;
  logic       blink_q, blink_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  // BCD increment of a 00..59 field. Result is {wrap, tens, ones}; wrap is
  // set when the field rolls 59 -> 00.
  function automatic logic [8:0] inc_field(input logic [3:0] tens,
                                           input logic [3:0] ones);
    logic [8:0] r;
    if (ones == 4'd9) begin
      if (tens == 4'd5) r = {1'b1, 4'd0, 4'd0};
      else              r = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      r = {1'b0, tens, ones + 4'd1};
    end
    return r;
  endfunction

  logic [8:0] sec_inc;
  logic [8:0] min_inc;

  assign sec_inc = inc_field(sec_tens_q, sec_ones_q);
  assign min_inc = inc_field(min_tens_q, min_ones_q);

  always_comb begin
    // pause toggles only outside ADJ; the flag survives a trip through ADJ
    paused_d = paused_q;
    if (pause_pulse && (state_q != ST_ADJ)) paused_d = ~paused_q;

    // adj has priority; otherwise the freshly updated pause flag decides
    if (adj)           state_d = ST_ADJ;
    else if (paused_d) state_d = ST_PAUSED;
    else               state_d = ST_RUN;

    // blink phase only runs in ADJ; any other state clears it
    blink_d = 1'b0;
    if (state_q == ST_ADJ) blink_d = blink_q ^ four_hz_tick;

    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    // mode decisions use the registered state, so an adj edge takes effect
    // one cycle later
    if ((state_q == ST_RUN) && one_hz_tick) begin
      sec_tens_d = sec_inc[7:4];
      sec_ones_d = sec_inc[3:0];
      if (sec_inc[8]) begin
        min_tens_d = min_inc[7:4];
        min_ones_d = min_inc[3:0];
      end
    end else if ((state_q == ST_ADJ) && two_hz_tick) begin
      // adjusting seconds never carries into minutes
      if (sel) begin
        sec_tens_d = sec_inc[7:4];
        sec_ones_d = sec_inc[3:0];
      end else begin
        min_tens_d = min_inc[7:4];
        min_ones_d = min_inc[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      paused_q   <= 1'b0;
      blink_q    <= 1'b0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      paused_q   <= paused_d;
      blink_q    <= blink_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign running   = (state_q == ST_RUN);
  // sel is taken live so a field switch moves the blink immediately
  assign blank_min = (state_q == ST_ADJ) & ~sel & blink_q;
  assign blank_sec = (state_q == ST_ADJ) &  sel & blink_q;
  assign state_dbg = state_q;

endmodule
